// File: rtl/johnson_pkg.sv
// Shared Johnson-code helpers: FSM state type, successor function and code-to-index map.
// Functions work on JW_MAX-wide words with the live width passed in, so any N up to JW_MAX works.
package johnson_pkg;
  localparam int JW_MAX = 32;
  localparam int JI_W   = 8;

  typedef enum logic [1:0] {HUNT, TRACK, LOCKED} jstate_t;

  typedef struct packed {
    logic            legal;
    logic [JI_W-1:0] idx;
  } jmap_t;

  function automatic logic [JW_MAX-1:0] johnson_next(logic [JW_MAX-1:0] q, int n);
    logic [JW_MAX-1:0] r;
    r = '0;
    for (int i = 0; i < JW_MAX-1; i++)
      if (i < n-1) r[i] = q[i+1];
    r[n-1] = ~q[0];
    return r;
  endfunction

  // Index k<=n is k ones from the MSB down; index n+b is n-b ones from the LSB up.
  function automatic logic [JW_MAX-1:0] johnson_code(int k, int n);
    logic [JW_MAX-1:0] c;
    c = '0;
    for (int i = 0; i < JW_MAX; i++)
      if (i < n) c[i] = (k <= n) ? (i >= n-k) : (i < 2*n-k);
    return c;
  endfunction

  function automatic jmap_t johnson_to_idx(logic [JW_MAX-1:0] q, int n);
    jmap_t res;
    res = '0;
    for (int k = 0; k < 2*JW_MAX; k++)
      if (k < 2*n && q == johnson_code(k, n)) begin
        res.legal = 1'b1;
        res.idx   = JI_W'(k);
      end
    return res;
  endfunction
endpackage

// File: rtl/johnson_code_map.sv
// Combinational legality check and index decode of one N-bit Johnson word.
module johnson_code_map import johnson_pkg::*; #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(2*N)
) (
  input  logic [N-1:0]     code,
  output logic             legal,
  output logic [IDX_W-1:0] idx
);
  jmap_t m;
  logic  unused_idx;

  assign m          = johnson_to_idx(JW_MAX'(code), N);
  assign legal      = m.legal;
  assign idx        = m.idx[IDX_W-1:0];
  assign unused_idx = ^m.idx;
endmodule

// File: rtl/johnson_decoder.sv
// Johnson-code receiver: decodes qualified samples, tracks +1 sequencing, reports lock and errors.
module johnson_decoder import johnson_pkg::*; #(
  parameter int N        = 4,
  parameter int IDX_W    = $clog2(2*N),
  parameter int LOCK_CNT = 3,
  parameter int ERR_W    = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             din_valid,
  input  logic [N-1:0]     din,
  output logic [IDX_W-1:0] dout,
  output logic             dout_valid,
  output logic             code_err,
  output logic             seq_err,
  output logic             locked,
  output logic [ERR_W-1:0] err_count
);
  localparam logic [3:0]       LOCK_C = 4'(LOCK_CNT);
  localparam logic [IDX_W-1:0] LAST   = IDX_W'(2*N-1);

  jstate_t          state, state_n;
  logic [3:0]       good, good_n;
  logic [IDX_W-1:0] prev, prev_n, dout_n, exp_idx, idx;
  logic             legal, dv_n, ce_n, se_n, err_inc;

  johnson_code_map #(.N(N), .IDX_W(IDX_W)) u_map (
    .code  (din),
    .legal (legal),
    .idx   (idx)
  );

  assign exp_idx = (prev == LAST) ? '0 : prev + 1'b1;
  assign locked  = (state == LOCKED);

  always_comb begin
    state_n = state;
    good_n  = good;
    prev_n  = prev;
    dout_n  = dout;
    dv_n    = 1'b0;
    ce_n    = 1'b0;
    se_n    = 1'b0;
    err_inc = 1'b0;
    if (din_valid) begin
      if (!legal) begin
        ce_n    = 1'b1;
        err_inc = 1'b1;
        state_n = HUNT;
        good_n  = '0;
      end else begin
        dout_n = idx;
        dv_n   = 1'b1;
        prev_n = idx;
        unique case (state)
          HUNT: begin
            state_n = TRACK;
            good_n  = '0;
          end
          TRACK: begin
            if (idx == exp_idx) begin
              if (good + 4'd1 == LOCK_C) begin
                state_n = LOCKED;
                good_n  = '0;
              end else begin
                good_n = good + 4'd1;
              end
            end else begin
              // Mismatch while still acquiring just re-seeds the reference.
              good_n = '0;
            end
          end
          LOCKED: begin
            if (idx != exp_idx) begin
              se_n    = 1'b1;
              err_inc = 1'b1;
              state_n = TRACK;
              good_n  = '0;
            end
          end
          default: state_n = HUNT;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= HUNT;
      good       <= '0;
      prev       <= '0;
      dout       <= '0;
      dout_valid <= 1'b0;
      code_err   <= 1'b0;
      seq_err    <= 1'b0;
      err_count  <= '0;
    end else begin
      state      <= state_n;
      good       <= good_n;
      prev       <= prev_n;
      dout       <= dout_n;
      dout_valid <= dv_n;
      code_err   <= ce_n;
      seq_err    <= se_n;
      if (err_inc && err_count != {ERR_W{1'b1}})
        err_count <= err_count + 1'b1;
    end
  end
endmodule

// File: tb/tb_johnson_decoder.sv
// Two decoders (N=2 and N=4 with a 2-bit error counter) driven by directed then random
// stimulus, compared every cycle against a run-length reference model.
module tb_johnson_decoder;
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst, va, vb;
  logic [1:0] da;
  logic [3:0] db;
  logic [0:0] a_dout_unused;
  logic [1:0] a_dout;
  logic [2:0] b_dout;
  logic       a_dv, a_ce, a_se, a_lk, b_dv, b_ce, b_se, b_lk;
  logic [7:0] a_err;
  logic [1:0] b_err;

  johnson_decoder #(.N(2), .LOCK_CNT(3), .ERR_W(8)) u_a (
    .clk(clk), .rst(rst), .din_valid(va), .din(da), .dout(a_dout),
    .dout_valid(a_dv), .code_err(a_ce), .seq_err(a_se), .locked(a_lk), .err_count(a_err));

  johnson_decoder #(.N(4), .LOCK_CNT(3), .ERR_W(2)) u_b (
    .clk(clk), .rst(rst), .din_valid(vb), .din(db), .dout(b_dout),
    .dout_valid(b_dv), .code_err(b_ce), .seq_err(b_se), .locked(b_lk), .err_count(b_err));

  int total = 0, bad = 0;

  task automatic chk(string tag, logic [31:0] got, logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Reference: locked means a run of >= LOCK_CNT consecutive +1 steps since the last reference.
  typedef struct {
    int n, lockc, emax;
    bit have_ref;
    int streak, prev, dout, err;
    bit dv, ce, se;
  } mdl_t;

  function automatic int jcode(int n, int k);
    if (k <= n) return ((1 << k) - 1) << (n - k);
    return (1 << (2*n - k)) - 1;
  endfunction

  function automatic int jidx(int n, int d);
    for (int k = 0; k < 2*n; k++)
      if (d == jcode(n, k)) return k;
    return -1;
  endfunction

  function automatic bit mlocked(mdl_t m);
    return m.have_ref && m.streak >= m.lockc;
  endfunction

  function automatic mdl_t mstep(mdl_t m, bit r, bit v, int d);
    int k;
    if (!r) begin
      m.have_ref = 0; m.streak = 0; m.prev = 0; m.dout = 0; m.err = 0;
      m.dv = 0; m.ce = 0; m.se = 0;
      return m;
    end
    m.dv = 0; m.ce = 0; m.se = 0;
    if (!v) return m;
    k = jidx(m.n, d);
    if (k < 0) begin
      m.ce = 1;
      if (m.err < m.emax) m.err++;
      m.have_ref = 0; m.streak = 0;
      return m;
    end
    m.dv = 1; m.dout = k;
    if (!m.have_ref) begin
      m.have_ref = 1; m.streak = 0;
    end else if (k == (m.prev + 1) % (2*m.n)) begin
      if (m.streak < m.lockc) m.streak++;
    end else begin
      if (m.streak >= m.lockc) begin
        m.se = 1;
        if (m.err < m.emax) m.err++;
      end
      m.streak = 0;
    end
    m.prev = k;
    return m;
  endfunction

  mdl_t ma, mb;

  task automatic step(bit r, bit v1, int d1, bit v2, int d2);
    @(negedge clk);
    rst = r; va = v1; da = 2'(d1); vb = v2; db = 4'(d2);
    @(posedge clk);
    ma = mstep(ma, r, v1, d1 & 3);
    mb = mstep(mb, r, v2, d2 & 15);
    #1;
    chk("a.dout", 32'(a_dout), ma.dout);  chk("a.dv", 32'(a_dv), 32'(ma.dv));
    chk("a.ce", 32'(a_ce), 32'(ma.ce));   chk("a.se", 32'(a_se), 32'(ma.se));
    chk("a.lock", 32'(a_lk), 32'(mlocked(ma))); chk("a.err", 32'(a_err), ma.err);
    chk("b.dout", 32'(b_dout), mb.dout);  chk("b.dv", 32'(b_dv), 32'(mb.dv));
    chk("b.ce", 32'(b_ce), 32'(mb.ce));   chk("b.se", 32'(b_se), 32'(mb.se));
    chk("b.lock", 32'(b_lk), 32'(mlocked(mb))); chk("b.err", 32'(b_err), mb.err);
  endtask

  task automatic gen(int n, inout int cur, output bit v, output int d);
    int r;
    r = $urandom_range(0, 99);
    v = 1; d = 0;
    if (r < 8) v = 0;
    else if (r < 14) d = int'($urandom & 32'((1 << n) - 1));
    else if (r < 20) begin cur = $urandom_range(0, 2*n-1); d = jcode(n, cur); end
    else begin cur = (cur + 1) % (2*n); d = jcode(n, cur); end
  endtask

  // N=4 directed list: index, -1 = illegal 0101, -2 = valid low.
  int seq_b[] = '{4, 5, 6, 7, 0, -1, 1, 2, 3, 4, 5, 6, 7, 0, 1, 2, 3,
                  1, 2, 3, 4, 5, -2, 6, -2, 7, -2, 0, -1, -1, -1, -1, -1};

  initial begin
    int ca, cb, d1, d2;
    bit v1, v2, r;
    ma = '{n: 2, lockc: 3, emax: 255, default: 0};
    mb = '{n: 4, lockc: 3, emax: 3, default: 0};
    rst = 0; va = 0; vb = 0; da = 0; db = 0;
    step(0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0);

    foreach (seq_b[i]) begin
      if (i < 5) step(1, 1, jcode(2, i % 4), 0, 0);
      else       step(1, 0, 0, 0, 0);
    end
    chk("a.plan_lock", 32'(a_lk), 32'd1);
    chk("a.plan_dout", 32'(a_dout), 32'd0);

    foreach (seq_b[i]) begin
      if (seq_b[i] == -1)      step(1, 0, 0, 1, 4'b0101);
      else if (seq_b[i] == -2) step(1, 0, 0, 0, 0);
      else                     step(1, 0, 0, 1, jcode(4, seq_b[i]));
    end
    chk("b.plan_sat", 32'(b_err), 32'd3);
    step(0, 0, 0, 1, jcode(4, 1));
    step(1, 0, 0, 1, jcode(4, 6));
    chk("b.plan_postrst_lock", 32'(b_lk), 32'd0);
    chk("b.plan_postrst_dv", 32'(b_dv), 32'd1);

    ca = 0; cb = 0;
    for (int i = 0; i < 3000; i++) begin
      gen(2, ca, v1, d1);
      gen(4, cb, v2, d2);
      r = ($urandom_range(0, 199) != 0);
      step(r, v1, d1, v2, d2);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
